correct_adder_8bit: RTL and testbench



---
 rtl/fp_mul_pkg.sv | 8 +
 rtl/half_adder.sv | 12 +
 rtl/correct_adder_8bit.sv | 74 +++++++
 tb/tb_correct_adder_8bit.sv | 136 +++++++++++++
 4 files changed

// File: rtl/fp_mul_pkg.sv
// Shared constants for the IEEE-754 single-precision multiplier datapath.
package fp_mul_pkg;

  localparam int          EXP_W    = 8;
  localparam logic [7:0]  EXP_MAX  = 8'hFF;
  localparam logic [7:0]  EXP_BIAS = 8'd127;

endpackage : fp_mul_pkg

// File: rtl/half_adder.sv
// One-bit half adder; chained to form the ripple incrementer of the exponent corrector.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule : half_adder

// File: rtl/correct_adder_8bit.sv
// Exponent-correction incrementer: registered sum_out = sum + carry with overflow flag.
// Optional macro CORRECT_ADDER_SATURATE_EN clamps sum_out to all-ones on overflow.
module correct_adder_8bit
  import fp_mul_pkg::*;
#(
  parameter int WIDTH = EXP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] sum,
  input  logic             carry,
  output logic [WIDTH-1:0] sum_out,
  output logic             out_valid,
  output logic             ovf
);

  logic [WIDTH:0]   chain_c_s;
  logic [WIDTH-1:0] inc_s;
  logic [WIDTH-1:0] sum_next_s;
  logic             ovf_next_s;

  logic [WIDTH-1:0] sum_out_r;
  logic             out_valid_r;
  logic             ovf_r;

  // The normalization carry enters at the LSB and ripples up the chain.
  assign chain_c_s[0] = carry;

  for (genvar i = 0; i < WIDTH; i++) begin : g_inc
    half_adder u_ha (
      .a (sum[i]),
      .b (chain_c_s[i]),
      .s (inc_s[i]),
      .c (chain_c_s[i+1])
    );
  end

  assign ovf_next_s = chain_c_s[WIDTH];

  // Select the corrected exponent: wrap or clamp on overflow.
  always_comb begin
    sum_next_s = inc_s;
`ifdef CORRECT_ADDER_SATURATE_EN
    if (ovf_next_s) begin
      sum_next_s = {WIDTH{1'b1}};
    end else begin
      sum_next_s = inc_s;
    end
`else
    sum_next_s = inc_s;
`endif
  end

  // Output register stage; results load only on accepted inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_out_r   <= {WIDTH{1'b0}};
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= (in_valid === 1'b1);
      if (in_valid) begin
        sum_out_r <= sum_next_s;
        ovf_r     <= ovf_next_s;
      end
    end
  end

  assign sum_out   = sum_out_r;
  assign ovf       = ovf_r;
  assign out_valid = out_valid_r;

endmodule : correct_adder_8bit

// File: tb/tb_correct_adder_8bit.sv
// Directed scoreboard bench for correct_adder_8bit.
module tb_correct_adder_8bit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] sum;
  logic       carry;
  logic [7:0] sum_out;
  logic       out_valid;
  logic       ovf;

  typedef struct packed {
    logic [7:0] s;
    logic       o;
  } exp_t;

  exp_t sb[$];
  exp_t held;
  int   errors = 0;
  int   checks = 0;

  correct_adder_8bit #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .sum       (sum),
    .carry     (carry),
    .sum_out   (sum_out),
    .out_valid (out_valid),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [7:0] s, input logic c);
    logic [8:0] r;
    exp_t e;
    r = {1'b0, s} + {8'd0, c};
    e.o = r[8];
    e.s = r[7:0];
`ifdef CORRECT_ADDER_SATURATE_EN
    if (r[8]) e.s = 8'hFF;
`endif
    return e;
  endfunction

  task automatic step(input string tag, input logic v, input logic [7:0] s, input logic c);
    exp_t e;
    in_valid = v;
    sum      = s;
    carry    = c;
    if (v) sb.push_back(model(s, c));
    @(posedge clk);
    #1;
    chk({tag, ".out_valid"}, {8'd0, out_valid}, {8'd0, v});
    if (v) begin
      if (sb.size() == 0) begin
        chk({tag, ".sb_empty"}, 9'd1, 9'd0);
      end else begin
        e = sb.pop_front();
        chk({tag, ".sum_out"}, {1'b0, sum_out}, {1'b0, e.s});
        chk({tag, ".ovf"}, {8'd0, ovf}, {8'd0, e.o});
        held = e;
      end
    end else begin
      chk({tag, ".hold_sum"}, {1'b0, sum_out}, {1'b0, held.s});
      chk({tag, ".hold_ovf"}, {8'd0, ovf}, {8'd0, held.o});
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    sum      = 8'h00;
    carry    = 1'b0;
    held     = '0;
    #2;
    chk("rst.sum_out", {1'b0, sum_out}, 9'd0);
    chk("rst.ovf", {8'd0, ovf}, 9'd0);
    chk("rst.out_valid", {8'd0, out_valid}, 9'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    step("s55c1", 1'b1, 8'h55, 1'b1);
    step("s55c0", 1'b1, 8'h55, 1'b0);
    step("sFFc1", 1'b1, 8'hFF, 1'b1);
    step("s7Fc1", 1'b1, 8'h7F, 1'b1);
    step("s00c0", 1'b1, 8'h00, 1'b0);
    step("b2b0", 1'b1, 8'h01, 1'b1);
    step("b2b1", 1'b1, 8'h10, 1'b0);
    step("b2b2", 1'b1, 8'hFE, 1'b1);
    step("idle", 1'b0, 8'h00, 1'b0);
    step("idle_x", 1'b0, 8'hxx, 1'bx);
    step("sFFc0", 1'b1, 8'hFF, 1'b0);
    step("sAAc1", 1'b1, 8'hAA, 1'b1);

    // Reset asserted between edges while a valid input is pending.
    in_valid = 1'b1;
    sum      = 8'h33;
    carry    = 1'b1;
    sb.push_back(model(8'h33, 1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst.sum_out", {1'b0, sum_out}, 9'd0);
    chk("mid_rst.ovf", {8'd0, ovf}, 9'd0);
    chk("mid_rst.out_valid", {8'd0, out_valid}, 9'd0);
    sb.delete();
    held = '0;
    @(posedge clk);
    #1;
    chk("in_rst.out_valid", {8'd0, out_valid}, 9'd0);
    chk("in_rst.sum_out", {1'b0, sum_out}, 9'd0);
    #3;
    rst_n = 1'b1;
    step("post_rst", 1'b1, 8'h20, 1'b1);
    step("post_idle", 1'b0, 8'h00, 1'b0);

    if (sb.size() != 0) chk("sb_drained", 9'd1, 9'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_correct_adder_8bit
